// File: rtl/chess_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chess_pkg                                                                  |
// | Shared square-word layout, colours, pawn allow-vector bits and FSM states. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package chess_pkg;

  localparam int SQ_OCC   = 0;
  localparam int SQ_COLOR = 1;
  localparam int SQ_KING  = 2;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  localparam int PA_FWD1 = 5;
  localparam int PA_FWD2 = 4;
  localparam int PA_CAPL = 3;
  localparam int PA_CAPR = 2;
  localparam int PA_EPL  = 1;
  localparam int PA_EPR  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_FETCH2 = 3'd3,
    ST_FETCH3 = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_RESP   = 3'd6
  } pawn_state_t;

endpackage
`default_nettype wire

// File: rtl/pawn_target_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pawn_target_calc                                                           |
// | Combinational target-square generator: (row, col, colour, k) -> addr.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pawn_target_calc
  import chess_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int IDXW    = $clog2(BOARD_N)
) (
  input  logic [IDXW-1:0]   i_row,
  input  logic [IDXW-1:0]   i_col,
  input  logic              i_color,
  input  logic [1:0]        i_k,
  output logic              o_in_board,
  output logic [2*IDXW-1:0] o_addr
);

  // Two guard bits give room for a sign and for row+2 overflow.
  localparam int c_W = IDXW + 2;
  localparam logic signed [c_W-1:0] c_P1 = (c_W)'(1);
  localparam logic signed [c_W-1:0] c_P2 = (c_W)'(2);
  localparam logic signed [c_W-1:0] c_M1 = -c_P1;
  localparam logic signed [c_W-1:0] c_M2 = -c_P2;
  localparam logic signed [c_W-1:0] c_N  = (c_W)'(BOARD_N);
  localparam logic [2*IDXW-1:0]     c_NA = (2*IDXW)'(BOARD_N);

  logic signed [c_W-1:0] w_dr;
  logic signed [c_W-1:0] w_dc;
  logic signed [c_W-1:0] w_tr;
  logic signed [c_W-1:0] w_tc;

  always_comb begin
    w_dr = (i_color == COLOR_BLACK) ? c_P1 : c_M1;
    if (i_k == 2'd1) begin
      w_dr = (i_color == COLOR_BLACK) ? c_P2 : c_M2;
    end
    w_dc = '0;
    if (i_k == 2'd2) begin
      w_dc = c_M1;
    end else if (i_k == 2'd3) begin
      w_dc = c_P1;
    end
    w_tr = $signed({2'b00, i_row}) + w_dr;
    w_tc = $signed({2'b00, i_col}) + w_dc;
  end

  assign o_in_board = ~w_tr[c_W-1] & (w_tr < c_N) & ~w_tc[c_W-1] & (w_tc < c_N);
  assign o_addr     = {{IDXW{1'b0}}, w_tr[IDXW-1:0]} * c_NA
                    + {{IDXW{1'b0}}, w_tc[IDXW-1:0]};

endmodule
`default_nettype wire

// File: rtl/pawn_move_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pawn_move_unit                                                             |
// | Sequential pawn move evaluator; fetches up to four squares per query.      |
// | Optional feature macro: PAWN_EP_EN (en passant tracking and epL/epR).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pawn_move_unit
  import chess_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int IDXW    = $clog2(BOARD_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDXW-1:0]   req_row,
  input  logic [IDXW-1:0]   req_col,
  input  logic              req_color,
  output logic              sq_rd_en,
  output logic [2*IDXW-1:0] sq_addr,
  input  logic [2:0]        sq_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [5:0]        rsp_allow,
  output logic              rsp_promo,
  input  logic              mv_valid,
  input  logic              mv_double,
  input  logic [IDXW-1:0]   mv_col,
  input  logic              mv_color
);

  localparam logic [IDXW-1:0] c_ROW_1  = IDXW'(1);
  localparam logic [IDXW-1:0] c_ROW_N2 = IDXW'(BOARD_N - 2);

  pawn_state_t       r_state;
  logic [IDXW-1:0]   r_row;
  logic [IDXW-1:0]   r_col;
  logic              r_color;
  logic [3:0]        r_inb;
  logic [1:0]        r_sq0;
  logic [1:0]        r_sq1;
  logic [1:0]        r_sq2;
  logic [5:0]        r_allow;
  logic              r_promo;

  logic              w_fetch;
  logic [1:0]        w_k;
  logic              w_tgt_inb;
  logic [2*IDXW-1:0] w_tgt_addr;
  logic              w_accept;
  logic              w_start_row;
  logic              w_fwd1;
  logic              w_fwd2;
  logic              w_capl;
  logic              w_capr;
  logic              w_epl;
  logic              w_epr;
  logic              w_promo;
  logic [5:0]        w_allow;

  always_comb begin
    w_fetch = 1'b1;
    w_k     = 2'd0;
    case (r_state)
      ST_FETCH0: w_k = 2'd0;
      ST_FETCH1: w_k = 2'd1;
      ST_FETCH2: w_k = 2'd2;
      ST_FETCH3: w_k = 2'd3;
      default:   w_fetch = 1'b0;
    endcase
  end

  pawn_target_calc #(
    .BOARD_N (BOARD_N),
    .IDXW    (IDXW)
  ) u_target (
    .i_row      (r_row),
    .i_col      (r_col),
    .i_color    (r_color),
    .i_k        (w_k),
    .o_in_board (w_tgt_inb),
    .o_addr     (w_tgt_addr)
  );

  assign w_accept  = (r_state == ST_IDLE) & req_valid;
  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign sq_rd_en  = w_fetch & w_tgt_inb;
  assign sq_addr   = sq_rd_en ? w_tgt_addr : '0;
  assign rsp_allow = r_allow;
  assign rsp_promo = r_promo;

`ifdef PAWN_EP_EN
  localparam logic [IDXW-1:0] c_ONE      = IDXW'(1);
  localparam logic [IDXW-1:0] c_LAST_COL = IDXW'(BOARD_N - 1);
  localparam logic [IDXW-1:0] c_EP_ROW_W = IDXW'(BOARD_N / 2 - 1);
  localparam logic [IDXW-1:0] c_EP_ROW_B = IDXW'(BOARD_N / 2);

  logic            r_ep_valid;
  logic [IDXW-1:0] r_ep_col;
  logic            r_ep_color;
  logic            r_snap_valid;
  logic [IDXW-1:0] r_snap_col;
  logic            r_snap_color;
  logic            w_ep_row;
  logic            w_ep_ok;
  logic            w_unused_bits;

  // The snapshot is taken from the pre-update register so that a move
  // notified in the accept cycle never leaks into the query being started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ep_valid   <= 1'b0;
      r_ep_col     <= '0;
      r_ep_color   <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap_col   <= '0;
      r_snap_color <= 1'b0;
    end else begin
      if (mv_valid) begin
        r_ep_valid <= mv_double;
        if (mv_double) begin
          r_ep_col   <= mv_col;
          r_ep_color <= mv_color;
        end
      end
      if (w_accept) begin
        r_snap_valid <= r_ep_valid;
        r_snap_col   <= r_ep_col;
        r_snap_color <= r_ep_color;
      end
    end
  end

  assign w_ep_row = (r_color == COLOR_BLACK) ? (r_row == c_EP_ROW_B) : (r_row == c_EP_ROW_W);
  assign w_ep_ok  = r_snap_valid & (r_snap_color != r_color) & w_ep_row;
  assign w_epl    = w_ep_ok & (r_col != '0)        & (r_snap_col == r_col - c_ONE);
  assign w_epr    = w_ep_ok & (r_col != c_LAST_COL) & (r_snap_col == r_col + c_ONE);
  assign w_unused_bits = sq_rdata[SQ_KING];
`else
  logic w_unused_bits;
  assign w_epl = 1'b0;
  assign w_epr = 1'b0;
  assign w_unused_bits = sq_rdata[SQ_KING] ^ mv_valid ^ mv_double ^ (^mv_col) ^ mv_color;
`endif

  // Target 3 is still on sq_rdata during DRAIN, so it is used directly.
  assign w_start_row = (r_color == COLOR_BLACK) ? (r_row == c_ROW_1) : (r_row == c_ROW_N2);
  assign w_promo     = (r_color == COLOR_BLACK) ? (r_row == c_ROW_N2) : (r_row == c_ROW_1);
  assign w_fwd1 = r_inb[0] & ~r_sq0[SQ_OCC];
  assign w_fwd2 = w_fwd1 & r_inb[1] & ~r_sq1[SQ_OCC] & w_start_row;
  assign w_capl = r_inb[2] & r_sq2[SQ_OCC] & (r_sq2[SQ_COLOR] != r_color);
  assign w_capr = r_inb[3] & sq_rdata[SQ_OCC] & (sq_rdata[SQ_COLOR] != r_color);

  always_comb begin
    w_allow          = '0;
    w_allow[PA_FWD1] = w_fwd1;
    w_allow[PA_FWD2] = w_fwd2;
    w_allow[PA_CAPL] = w_capl;
    w_allow[PA_CAPR] = w_capr;
    w_allow[PA_EPL]  = w_epl;
    w_allow[PA_EPR]  = w_epr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_color <= 1'b0;
      r_inb   <= '0;
      r_sq0   <= '0;
      r_sq1   <= '0;
      r_sq2   <= '0;
      r_allow <= '0;
      r_promo <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_row   <= req_row;
            r_col   <= req_col;
            r_color <= req_color;
            r_state <= ST_FETCH0;
          end
        end
        ST_FETCH0: begin
          r_inb[0] <= w_tgt_inb;
          r_state  <= ST_FETCH1;
        end
        ST_FETCH1: begin
          r_inb[1] <= w_tgt_inb;
          r_sq0    <= sq_rdata[1:0];
          r_state  <= ST_FETCH2;
        end
        ST_FETCH2: begin
          r_inb[2] <= w_tgt_inb;
          r_sq1    <= sq_rdata[1:0];
          r_state  <= ST_FETCH3;
        end
        ST_FETCH3: begin
          r_inb[3] <= w_tgt_inb;
          r_sq2    <= sq_rdata[1:0];
          r_state  <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_allow <= w_allow;
          r_promo <= w_promo;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pawn_move_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pawn_move_unit                                                          |
// | Directed self-checking bench for pawn_move_unit on an 8x8 board.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pawn_move_unit;

  localparam int N  = 8;
  localparam int IW = 3;

`ifdef PAWN_EP_EN
  localparam logic [5:0] EXP_EPR = 6'b000001;
  localparam logic [5:0] EXP_EPL = 6'b000010;
`else
  localparam logic [5:0] EXP_EPR = 6'b000000;
  localparam logic [5:0] EXP_EPL = 6'b000000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_row;
  logic [IW-1:0] req_col;
  logic          req_color;
  logic          sq_rd_en;
  logic [2*IW-1:0] sq_addr;
  logic [2:0]    sq_rdata = 3'b111;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [5:0]    rsp_allow;
  logic          rsp_promo;
  logic          mv_valid;
  logic          mv_double;
  logic [IW-1:0] mv_col;
  logic          mv_color;

  logic [2:0] board [0:N*N-1];
  logic [2:0] pend = 3'b111;
  int addr_log[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pawn_move_unit #(.BOARD_N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_color (req_color),
    .sq_rd_en  (sq_rd_en),
    .sq_addr   (sq_addr),
    .sq_rdata  (sq_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_allow (rsp_allow),
    .rsp_promo (rsp_promo),
    .mv_valid  (mv_valid),
    .mv_double (mv_double),
    .mv_col    (mv_col),
    .mv_color  (mv_color)
  );

  // One-cycle-latency board store; unread cycles return junk on purpose.
  always @(negedge clk) begin
    sq_rdata = pend;
    pend = sq_rd_en ? board[sq_addr] : 3'b111;
    if (sq_rd_en) addr_log.push_back(int'(sq_addr));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  function automatic string log_str();
    string s = "";
    foreach (addr_log[i]) s = {s, $sformatf("%0d ", addr_log[i])};
    return s;
  endfunction

  function automatic bit log_is(input int e[$]);
    if (addr_log.size() != e.size()) return 1'b0;
    foreach (e[i]) if (addr_log[i] != e[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_board();
    for (int i = 0; i < N*N; i++) board[i] = 3'b000;
  endtask

  task automatic do_query(input logic [IW-1:0] r, input logic [IW-1:0] c, input logic color,
                          input logic mv_clr, output logic [5:0] allow, output logic promo,
                          output int lat);
    @(negedge clk);
    addr_log.delete();
    req_row = r; req_col = c; req_color = color; req_valid = 1'b1;
    if (mv_clr) begin mv_valid = 1'b1; mv_double = 1'b0; end
    @(negedge clk);
    req_valid = 1'b0; mv_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    allow = rsp_allow; promo = rsp_promo;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic mv_pulse(input logic dbl, input logic [IW-1:0] col, input logic color);
    @(negedge clk);
    mv_valid = 1'b1; mv_double = dbl; mv_col = col; mv_color = color;
    @(negedge clk);
    mv_valid = 1'b0; mv_double = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_row = '0; req_col = '0;
    req_color = 1'b0; mv_valid = 1'b0; mv_double = 1'b0; mv_col = '0; mv_color = 1'b0;
    clear_board();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_allow, rsp_promo, sq_rd_en, sq_addr} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b allow=%b promo=%b rd=%b addr=%0d, required 1 0 000000 0 0 0",
               req_ready, rsp_valid, rsp_allow, rsp_promo, sq_rd_en, sq_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_idle: got rdy=%b vld=%b, required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_empty_board();
    logic [5:0] a; logic p; int lat; int e[$];
    clear_board();
    do_query(3'd6, 3'd4, 1'b0, 1'b0, a, p, lat);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL latency: got %0d, required 6", lat); end
    checks++;
    if ({a, p} !== {6'b110000, 1'b0}) begin
      failures++; $display("FAIL white_start_empty: got allow=%b promo=%b, required 110000 0", a, p);
    end
    e = '{44, 36, 43, 45};
    checks++;
    if (!log_is(e)) begin failures++; $display("FAIL reads_white_start: got %s, required 44 36 43 45", log_str()); end
  endtask

  task automatic test_edge_capture();
    logic [5:0] a; logic p; int lat; int e[$];
    clear_board();
    board[0*N+1] = 3'b011;
    do_query(3'd1, 3'd0, 1'b0, 1'b0, a, p, lat);
    checks++;
    if ({a, p} !== {6'b100100, 1'b1}) begin
      failures++; $display("FAIL white_left_edge: got allow=%b promo=%b, required 100100 1", a, p);
    end
    e = '{0, 1};
    checks++;
    if (!log_is(e)) begin failures++; $display("FAIL reads_left_edge: got %s, required 0 1", log_str()); end
  endtask

  task automatic test_black_capture();
    logic [5:0] a; logic p; int lat; int e[$];
    clear_board();
    board[2*N+4] = 3'b001;
    board[2*N+2] = 3'b011;
    board[3*N+3] = 3'b001;
    do_query(3'd1, 3'd3, 1'b1, 1'b0, a, p, lat);
    checks++;
    if ({a, p} !== {6'b100100, 1'b0}) begin
      failures++; $display("FAIL black_capture: got allow=%b promo=%b, required 100100 0", a, p);
    end
    e = '{19, 27, 18, 20};
    checks++;
    if (!log_is(e)) begin failures++; $display("FAIL reads_black: got %s, required 19 27 18 20", log_str()); end
  endtask

  task automatic test_boundaries();
    logic [5:0] a; logic p; int lat; int e[$];
    clear_board();
    board[7*N+6] = 3'b101;
    do_query(3'd6, 3'd7, 1'b1, 1'b0, a, p, lat);
    checks++;
    if ({a, p} !== {6'b101000, 1'b1}) begin
      failures++; $display("FAIL black_right_edge_king: got allow=%b promo=%b, required 101000 1", a, p);
    end
    e = '{63, 62};
    checks++;
    if (!log_is(e)) begin failures++; $display("FAIL reads_right_edge: got %s, required 63 62", log_str()); end
    clear_board();
    do_query(3'd0, 3'd3, 1'b0, 1'b0, a, p, lat);
    checks++;
    if ({a, p, addr_log.size()} !== {6'b000000, 1'b0, 32'd0}) begin
      failures++; $display("FAIL white_top_row: got allow=%b promo=%b reads=%0d, required 000000 0 0", a, p, addr_log.size());
    end
  endtask

  task automatic test_en_passant();
    logic [5:0] a; logic p; int lat;
    clear_board();
    board[2*N+4] = 3'b011;
    mv_pulse(1'b1, 3'd5, 1'b1);
    do_query(3'd3, 3'd4, 1'b0, 1'b0, a, p, lat);
    checks++;
    if (a !== EXP_EPR) begin failures++; $display("FAIL ep_right: got %b, required %b", a, EXP_EPR); end
    do_query(3'd3, 3'd4, 1'b0, 1'b1, a, p, lat);
    checks++;
    if (a !== EXP_EPR) begin failures++; $display("FAIL ep_snapshot: got %b, required %b", a, EXP_EPR); end
    do_query(3'd3, 3'd4, 1'b0, 1'b0, a, p, lat);
    checks++;
    if (a !== 6'b000000) begin failures++; $display("FAIL ep_cleared: got %b, required 000000", a); end
    mv_pulse(1'b1, 3'd3, 1'b1);
    do_query(3'd3, 3'd4, 1'b0, 1'b0, a, p, lat);
    checks++;
    if (a !== EXP_EPL) begin failures++; $display("FAIL ep_left: got %b, required %b", a, EXP_EPL); end
    mv_pulse(1'b1, 3'd5, 1'b0);
    do_query(3'd3, 3'd4, 1'b0, 1'b0, a, p, lat);
    checks++;
    if (a !== 6'b000000) begin failures++; $display("FAIL ep_same_colour: got %b, required 000000", a); end
    mv_pulse(1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_stall();
    int lat;
    clear_board();
    @(negedge clk);
    req_row = 3'd6; req_col = 3'd4; req_color = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    addr_log.delete();
    req_row = 3'd1; req_col = 3'd0; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_allow, rsp_promo, req_ready} !== {1'b1, 6'b110000, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got vld=%b allow=%b promo=%b rdy=%b, required 1 110000 0 0",
                 i, rsp_valid, rsp_allow, rsp_promo, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, addr_log.size()} !== {1'b1, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL stall_no_accept: got rdy=%b vld=%b reads=%0d, required 1 0 0", req_ready, rsp_valid, addr_log.size());
    end
  endtask

  task automatic test_back_to_back();
    int times[$]; int ovl; int bad_data;
    clear_board();
    ovl = 0; bad_data = 0;
    @(negedge clk);
    req_row = 3'd6; req_col = 3'd4; req_color = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        times.push_back(i);
        if (req_ready) ovl++;
        if (rsp_allow !== 6'b110000) bad_data++;
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (times.size() != 3 || times[0] != 6 || times[1] != 13 || times[2] != 20) begin
      failures++;
      $display("FAIL b2b_timing: got %0d responses first=%0d, required 3 at cycles 6 13 20",
               times.size(), (times.size() > 0) ? times[0] : -1);
    end
    checks++;
    if (ovl != 0 || bad_data != 0) begin
      failures++; $display("FAIL b2b_ready_data: got overlap=%0d bad=%0d, required 0 0", ovl, bad_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] a; logic p; int lat;
    clear_board();
    @(negedge clk);
    req_row = 3'd6; req_col = 3'd4; req_color = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sq_rd_en, sq_addr} !== {1'b1, 6'd43}) begin
      failures++; $display("FAIL mid_fetch2: got rd=%b addr=%0d, required 1 43", sq_rd_en, sq_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_allow, rsp_promo, sq_rd_en, sq_addr} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL mid_reset_async: got rdy=%b vld=%b allow=%b promo=%b rd=%b addr=%0d, required 1 0 000000 0 0 0",
               req_ready, rsp_valid, rsp_allow, rsp_promo, sq_rd_en, sq_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) lat++;
    end
    checks++;
    if (lat != 0) begin failures++; $display("FAIL mid_reset_no_rsp: got %0d valid cycles, required 0", lat); end
    board[2*N+4] = 3'b001;
    board[2*N+2] = 3'b011;
    board[3*N+3] = 3'b001;
    do_query(3'd1, 3'd3, 1'b1, 1'b0, a, p, lat);
    checks++;
    if ({a, p, lat} !== {6'b100100, 1'b0, 32'd6}) begin
      failures++; $display("FAIL after_reset_query: got allow=%b promo=%b lat=%0d, required 100100 0 6", a, p, lat);
    end
  endtask

  initial begin
    test_reset();
    test_empty_board();
    test_edge_capture();
    test_black_capture();
    test_boundaries();
    test_en_passant();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
